// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Active-low 7-segment patterns, bit 0 = a .. bit 6 = g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Digit patterns 0..9, entry k is the pattern for digit k
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Double-dabble digit correction; result never exceeds 12, so no carry out
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Non-decimal codes cannot occur in a valid result; show them blank
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit add-3-if->=5 correction stage.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = add3(d);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional active-low 7-segment output enabled by defining SEG_DECODE_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned W_IN     = 8,
  parameter int unsigned N_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [W_IN-1:0]         bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   bcd,
`ifdef SEG_DECODE_EN
  output logic [7*N_DIGITS-1:0]   seg,
`endif
  output logic                    ovf
);

  localparam int unsigned CW = (W_IN > 1) ? $clog2(W_IN) : 1;

  state_t                  state, state_nxt;
  logic                    load, step, fin;
  logic [W_IN-1:0]         sh;
  logic [4*N_DIGITS-1:0]   scr;
  logic [4*N_DIGITS-1:0]   adj;
  logic                    ovf_acc;
  logic [CW-1:0]           cnt;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scr[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == '0) state_nxt = FIN;
      end
      FIN: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEG_DECODE_EN
  logic [7*N_DIGITS-1:0] seg_nxt;
  logic                  seg_lead;

  // Segment patterns from the finished scratch digits; scanned MSB digit first
  // so leading zeros blank until the first nonzero digit, units always shown
  always_comb begin
    seg_nxt  = '1;
    seg_lead = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (ovf_acc) begin
        seg_nxt[7*(N_DIGITS-1-i) +: 7] = SEG_DASH;
      end else if (seg_lead && scr[4*(N_DIGITS-1-i) +: 4] == 4'd0 && i != N_DIGITS-1) begin
        seg_nxt[7*(N_DIGITS-1-i) +: 7] = SEG_BLANK;
      end else begin
        seg_lead = 1'b0;
        seg_nxt[7*(N_DIGITS-1-i) +: 7] = seg_of(scr[4*(N_DIGITS-1-i) +: 4]);
      end
    end
  end
`endif

  // Shift/adjust datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      scr     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
`ifdef SEG_DECODE_EN
      seg     <= '1;
`endif
    end else begin
      busy <= (state_nxt != IDLE);
      done <= fin;
      if (load) begin
        sh      <= bin;
        scr     <= '0;
        ovf_acc <= 1'b0;
        cnt     <= CW'(W_IN - 1);
      end
      if (step) begin
        sh      <= sh << 1;
        scr     <= {adj[4*N_DIGITS-2:0], sh[W_IN-1]};
        ovf_acc <= ovf_acc | adj[4*N_DIGITS-1];
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
      if (fin) begin
        bcd <= scr;
        ovf <= ovf_acc;
`ifdef SEG_DECODE_EN
        seg <= seg_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share
// the handshake inputs; results are compared with a decimal reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
`ifdef SEG_DECODE_EN
  logic [20:0] seg3;
  logic [13:0] seg2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W_IN(8), .N_DIGITS(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy3),
    .done  (done3),
    .bcd   (bcd3),
`ifdef SEG_DECODE_EN
    .seg   (seg3),
`endif
    .ovf   (ovf3)
  );

  bin_to_bcd_seq #(.W_IN(8), .N_DIGITS(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy2),
    .done  (done2),
    .bcd   (bcd2),
`ifdef SEG_DECODE_EN
    .seg   (seg2),
`endif
    .ovf   (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Low nd decimal digits of v, packed as BCD
  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r = r | (32'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] ref_digit_seg(input int d);
    logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    return tbl[d];
  endfunction

  // Display image of v on nd digits: dashes on overflow, else leading blanks
  function automatic logic [31:0] ref_seg(input int v, input int nd);
    logic [31:0] r = '0;
    int sig = 1;
    while (v >= pow10(sig) && sig < 10) sig++;
    for (int k = 0; k < nd; k++) begin
      if (v >= pow10(nd))  r = r | (32'(7'h3F) << (7 * k));
      else if (k >= sig)   r = r | (32'(7'h7F) << (7 * k));
      else                 r = r | (32'(ref_digit_seg((v / pow10(k)) % 10)) << (7 * k));
    end
    return r;
  endfunction

  // One conversion: start presented on the next edge, then wait for done
  task automatic run_conv(input int v, input bit noise);
    int lat = 0;
    @(negedge clk);
    bin   = 8'(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy3, 1'b1);
    check("done_is_pulse", done3, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (noise) bin = 8'($urandom);
      if (done3) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 9);
    check("busy_low_at_done", busy3, 1'b0);
    check("bcd3", bcd3, ref_bcd(v, 3));
    check("ovf3", ovf3, 1'b0);
    check("done2", done2, 1'b1);
    check("bcd2", bcd2, ref_bcd(v, 2));
    check("ovf2", ovf2, (v >= 100));
`ifdef SEG_DECODE_EN
    check("seg3", seg3, ref_seg(v, 3));
    check("seg2", seg2, ref_seg(v, 2));
`endif
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy3, 1'b0);
    check("rst_done", done3, 1'b0);
    check("rst_bcd", bcd3, 12'h000);
    check("rst_ovf", ovf3, 1'b0);
`ifdef SEG_DECODE_EN
    check("rst_seg", seg3, 21'h1FFFFF);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", busy3, 1'b0);
    check("post_rst_bcd", bcd3, 12'h000);

    // Main case and corners, including the overflow cases for the 2-digit instance
    run_conv(225, 1'b0);
    run_conv(0, 1'b0);
    run_conv(255, 1'b0);
    run_conv(9, 1'b0);
    run_conv(10, 1'b0);
    run_conv(7, 1'b0);
    run_conv(200, 1'b0);
    run_conv(99, 1'b0);
    run_conv(100, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    bin = 8'd144;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin
        bin = 8'd7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done3) begin
        dones++;
        check("ignored_start_bcd", bcd3, 12'h144);
      end
    end
    start = 1'b0;
    check("ignored_start_dones", dones, 1);

    // Reset mid-conversion aborts
    @(negedge clk);
    bin = 8'd99;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy3, 1'b0);
    check("abort_done", done3, 1'b0);
    check("abort_bcd", bcd3, 12'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done3) dones++;
    end
    check("abort_no_done", dones, 0);
    run_conv(99, 1'b0);

    // Exhaustive sweep, back-to-back starts
    for (int v = 0; v < 256; v++) run_conv(v, 1'b0);

    // Random operands, idle gaps, and operand noise while converting
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_conv($urandom_range(0, 255), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
